// File: rtl/cache_wt_nway_if.sv
// CPU-side and memory-side signal bundle for the write-through cache.
// slave = cache view, master = requester/memory-model view.
interface cache_wt_nway_if;
  logic        i_rd_en;
  logic        i_wr_en;
  logic        i_flush;
  logic [31:0] i_addr;
  logic [31:0] i_data;
  logic [3:0]  i_mask;
  logic [31:0] o_data;
  logic        o_busy;
  logic        o_hit;
  logic        o_mem_rd;
  logic        o_mem_wr;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_data;
  logic [3:0]  o_mem_mask;
  logic [31:0] i_mem_data;
  logic        i_mem_busy;

  modport slave (
    input  i_rd_en, i_wr_en, i_flush,
    input  i_addr, i_data, i_mask,
    output o_data, o_busy, o_hit,
    output o_mem_rd, o_mem_wr, o_mem_addr,
    output o_mem_data, o_mem_mask,
    input  i_mem_data, i_mem_busy
  );

  modport master (
    output i_rd_en, i_wr_en, i_flush,
    output i_addr, i_data, i_mask,
    input  o_data, o_busy, o_hit,
    input  o_mem_rd, o_mem_wr, o_mem_addr,
    input  o_mem_data, o_mem_mask,
    output i_mem_data, i_mem_busy
  );
endinterface

// File: rtl/cache_wt_nway.sv
// N-way set-associative write-through cache, no write allocate,
// round-robin victim per set, whole-cache flush one set per cycle.
module cache_wt_nway #(
  parameter int ADDR_WIDTH = 23,
  parameter int WAYS       = 2,
  parameter int SETS       = 256
) (
  input logic            clk,
  input logic            rst_x,
  cache_wt_nway_if.slave bus
);
  localparam int IW = $clog2(SETS);
  localparam int TW = ADDR_WIDTH - 2 - IW;
  localparam int PW = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOOKUP   = 3'd1;
  localparam logic [2:0] S_MREQ_RD  = 3'd2;
  localparam logic [2:0] S_MREQ_WR  = 3'd3;
  localparam logic [2:0] S_MWAIT_RD = 3'd4;
  localparam logic [2:0] S_MWAIT_WR = 3'd5;
  localparam logic [2:0] S_FLUSH    = 3'd6;

  logic [2:0]      r_state;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic [3:0]      r_mask;
  logic [IW-1:0]   r_fcnt;
  logic [WAYS-1:0] r_valid [SETS];
  logic [PW-1:0]   r_ptr   [SETS];
  logic [TW-1:0]   r_tag   [WAYS][SETS];
  logic [31:0]     r_word  [WAYS][SETS];

  logic [IW-1:0]   l_idx, w_idx;
  logic [TW-1:0]   l_tag, w_tag;
  logic [WAYS-1:0] l_hitv, w_hitv;
  logic [31:0]     l_word, w_word, w_merge;
  logic            l_hit, busy, do_wr, fill;
  logic [PW-1:0]   vic, ptr_nxt;
  logic            vic_inv;

  assign l_idx = r_addr[2 +: IW];
  assign l_tag = r_addr[2+IW +: TW];
  assign w_idx = bus.i_addr[2 +: IW];
  assign w_tag = bus.i_addr[2+IW +: TW];

  always_comb begin
    l_hitv = '0;
    w_hitv = '0;
    l_word = '0;
    w_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      l_hitv[w] = r_valid[l_idx][w] && (r_tag[w][l_idx] == l_tag);
      w_hitv[w] = r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag);
      if (l_hitv[w]) l_word = r_word[w][l_idx];
      if (w_hitv[w]) w_word = r_word[w][w_idx];
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++)
      w_merge[8*b +: 8] = bus.i_mask[b] ?
        bus.i_data[8*b +: 8] : w_word[8*b +: 8];
  end

  // Lowest invalid way wins over the round-robin pointer.
  always_comb begin
    vic     = r_ptr[l_idx];
    vic_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[l_idx][w]) begin
        vic     = PW'(w);
        vic_inv = 1'b1;
      end
    end
  end

  assign ptr_nxt = (r_ptr[l_idx] == PW'(WAYS - 1)) ?
    '0 : r_ptr[l_idx] + PW'(1);

  assign l_hit = |l_hitv;

  always_comb begin
    busy = 1'b1;
    unique case (r_state)
      S_IDLE:   busy = 1'b0;
      S_LOOKUP: busy = !l_hit;
      default:  busy = 1'b1;
    endcase
  end

  assign do_wr = !busy && !bus.i_flush &&
                 !bus.i_rd_en && bus.i_wr_en;
  assign fill  = (r_state == S_MWAIT_RD) && !bus.i_mem_busy;

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (do_wr && w_hitv[w])
        r_word[w][w_idx] <= w_merge;
      if (fill && (vic == PW'(w))) begin
        r_word[w][l_idx] <= bus.i_mem_data;
        r_tag[w][l_idx]  <= l_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_mask  <= '0;
      r_fcnt  <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_ptr[s]   <= '0;
      end
    end else begin
      unique case (r_state)
        S_IDLE, S_LOOKUP: begin
          if (busy) begin
            r_state <= S_MREQ_RD;
          end else if (bus.i_flush) begin
            r_state <= S_FLUSH;
            r_fcnt  <= '0;
          end else if (bus.i_rd_en) begin
            r_state <= S_LOOKUP;
            r_addr  <= bus.i_addr;
          end else if (bus.i_wr_en) begin
            r_state <= S_MREQ_WR;
            r_addr  <= bus.i_addr;
            r_wdata <= bus.i_data;
            r_mask  <= bus.i_mask;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_MREQ_RD:
          if (bus.i_mem_busy) r_state <= S_MWAIT_RD;
        S_MREQ_WR:
          if (bus.i_mem_busy) r_state <= S_MWAIT_WR;
        S_MWAIT_RD: begin
          if (!bus.i_mem_busy) begin
            r_state <= S_IDLE;
            r_rdata <= bus.i_mem_data;
            r_valid[l_idx][vic] <= 1'b1;
            if (!vic_inv) r_ptr[l_idx] <= ptr_nxt;
          end
        end
        S_MWAIT_WR:
          if (!bus.i_mem_busy) r_state <= S_IDLE;
        S_FLUSH: begin
          r_valid[r_fcnt] <= '0;
          r_fcnt <= r_fcnt + IW'(1);
          if (r_fcnt == IW'(SETS - 1)) begin
            r_state <= S_IDLE;
            for (int s = 0; s < SETS; s++) r_ptr[s] <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.o_busy     = busy;
  assign bus.o_hit      = (r_state == S_LOOKUP) && l_hit;
  assign bus.o_data     = bus.o_hit ? l_word : r_rdata;
  assign bus.o_mem_rd   = (r_state == S_MREQ_RD);
  assign bus.o_mem_wr   = (r_state == S_MREQ_WR);
  assign bus.o_mem_addr = r_addr;
  assign bus.o_mem_data = r_wdata;
  assign bus.o_mem_mask = r_mask;
endmodule

// File: tb/tb_cache_wt_nway.sv
// Bench for cache_wt_nway: directed table, corner sequences and
// random traffic against a memory model plus a set/tag cache model.
module tb_cache_wt_nway;
  localparam int WAYS = 2;
  localparam int SETS = 256;

  logic clk = 1'b0;
  logic rst_x = 1'b0;
  always #5 clk = ~clk;

  cache_wt_nway_if bus();

  cache_wt_nway #(
    .ADDR_WIDTH(23), .WAYS(WAYS), .SETS(SETS)
  ) dut (
    .clk(clk), .rst_x(rst_x), .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] mem_m [int];
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] last_data = '0;
  logic [3:0]  last_mask = '0;
  bit          resp_active = 1'b0;

  bit mv [WAYS][SETS];
  int mt [WAYS][SETS];
  int mp [SETS];

  function automatic logic [31:0] mem_val(logic [31:0] a);
    int k = int'(a[31:2]);
    if (mem_m.exists(k)) return mem_m[k];
    return {16'hA5A5, a[15:0]};
  endfunction

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < WAYS; w++) mv[w][s] = 1'b0;
    end
  endfunction

  // Returns predicted hit; on a miss installs the line.
  function automatic bit m_read(logic [31:0] a);
    int s = int'((a >> 2) % SETS);
    int t = int'((a % (1 << 23)) / (4 * SETS));
    int v = -1;
    for (int w = 0; w < WAYS; w++)
      if (mv[w][s] && mt[w][s] == t) return 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!mv[w][s]) v = w;
    if (v < 0) begin
      v = mp[s];
      mp[s] = (mp[s] + 1) % WAYS;
    end
    mv[v][s] = 1'b1;
    mt[v][s] = t;
    return 1'b0;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory responder: random request-to-busy delay and busy length.
  initial begin
    logic        is_wr;
    logic [31:0] a, d, cur;
    logic [3:0]  m;
    bus.i_mem_busy = 1'b0;
    bus.i_mem_data = '0;
    forever begin
      @(negedge clk);
      if (bus.o_mem_rd || bus.o_mem_wr) begin
        resp_active = 1'b1;
        is_wr = bus.o_mem_wr;
        a = bus.o_mem_addr;
        d = bus.o_mem_data;
        m = bus.o_mem_mask;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.i_mem_busy = 1'b1;
        repeat ($urandom_range(2, 4)) @(negedge clk);
        if (is_wr) begin
          cur = mem_val(a);
          for (int b = 0; b < 4; b++)
            if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
          mem_m[int'(a[31:2])] = cur;
          wr_cnt++;
          last_addr = a;
          last_data = d;
          last_mask = m;
        end else begin
          bus.i_mem_data = mem_val(a);
          rd_cnt++;
        end
        bus.i_mem_busy = 1'b0;
        resp_active = 1'b0;
      end
    end
  end

  task automatic wait_idle(string nm);
    int n = 0;
    while (bus.o_busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.o_busy) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: busy stuck got 1 expected 0", nm);
    end
  endtask

  task automatic cpu_read(input logic [31:0] a, input bit also_wr,
                          output bit hit, output logic [31:0] d);
    bus.i_rd_en = 1'b1;
    bus.i_wr_en = also_wr;
    bus.i_addr  = a;
    bus.i_data  = 32'h0BAD0BAD;
    bus.i_mask  = 4'hF;
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    hit = bus.o_hit;
    wait_idle("rd_timeout");
    d = bus.o_data;
  endtask

  task automatic cpu_write(input logic [31:0] a, d, input logic [3:0] m);
    bus.i_wr_en = 1'b1;
    bus.i_addr  = a;
    bus.i_data  = d;
    bus.i_mask  = m;
    @(negedge clk);
    bus.i_wr_en = 1'b0;
    chk("wr_busy", 32'(bus.o_busy), 32'd1);
    wait_idle("wr_timeout");
  endtask

  task automatic cpu_flush(output int n);
    bus.i_flush = 1'b1;
    @(negedge clk);
    bus.i_flush = 1'b0;
    n = 0;
    while (bus.o_busy && n < SETS + 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    bit          hit;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [11];

  initial begin
    bit          h;
    logic [31:0] d, a;
    int          r0, w0, n, r;
    logic [3:0]  m;

    vt[0]  = '{0, 32'h000, 0, 0, 0, 32'hA5A50000};
    vt[1]  = '{0, 32'h400, 0, 0, 0, 32'hA5A50400};
    vt[2]  = '{0, 32'h800, 0, 0, 0, 32'hA5A50800};
    vt[3]  = '{0, 32'h400, 0, 0, 1, 32'hA5A50400};
    vt[4]  = '{0, 32'h000, 0, 0, 0, 32'hA5A50000};
    vt[5]  = '{0, 32'h100, 0, 0, 0, 32'hDEADBEEF};
    vt[6]  = '{0, 32'h100, 0, 0, 1, 32'hDEADBEEF};
    vt[7]  = '{1, 32'h100, 32'h11223344, 4'b0101, 0, 0};
    vt[8]  = '{0, 32'h100, 0, 0, 1, 32'hDE22BE44};
    vt[9]  = '{1, 32'h2000, 32'hCAFEF00D, 4'hF, 0, 0};
    vt[10] = '{0, 32'h2000, 0, 0, 0, 32'hCAFEF00D};
    mem_m[int'(32'h100 >> 2)] = 32'hDEADBEEF;

    bus.i_rd_en = 1'b0;
    bus.i_wr_en = 1'b0;
    bus.i_flush = 1'b0;
    bus.i_addr  = '0;
    bus.i_data  = '0;
    bus.i_mask  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_hit", 32'(bus.o_hit), 0);
    chk("rst_data", bus.o_data, 0);
    chk("rst_mem_rd", 32'(bus.o_mem_rd), 0);
    chk("rst_mem_wr", 32'(bus.o_mem_wr), 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    rst_x = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      if (vt[i].wr) begin
        cpu_write(vt[i].addr, vt[i].data, vt[i].mask);
        chk($sformatf("t%0d_wr_cnt", i), wr_cnt - w0, 1);
        chk($sformatf("t%0d_wr_addr", i), last_addr, vt[i].addr);
        chk($sformatf("t%0d_wr_data", i), last_data, vt[i].data);
        chk($sformatf("t%0d_wr_mask", i), 32'(last_mask), 32'(vt[i].mask));
      end else begin
        cpu_read(vt[i].addr, 1'b0, h, d);
        chk($sformatf("t%0d_hit", i), 32'(h), 32'(vt[i].hit));
        chk($sformatf("t%0d_data", i), d, vt[i].exp);
        chk($sformatf("t%0d_rd_cnt", i), rd_cnt - r0, vt[i].hit ? 0 : 1);
      end
      chk($sformatf("t%0d_rd_wr", i), wr_cnt - w0, vt[i].wr ? 1 : 0);
    end

    for (int i = 0; i < 4; i++) cpu_read(32'h1000 + 32'(4 * i), 1'b0, h, d);
    cpu_flush(n);
    chk("flush_cycles", n, SETS);
    for (int i = 0; i < 4; i++) begin
      cpu_read(32'h1000 + 32'(4 * i), 1'b0, h, d);
      chk($sformatf("flush_reread%0d_hit", i), 32'(h), 0);
    end

    w0 = wr_cnt;
    cpu_read(32'h3000, 1'b1, h, d);
    chk("rdwr_hit", 32'(h), 0);
    chk("rdwr_data", d, 32'hA5A53000);
    cpu_read(32'h3000, 1'b0, h, d);
    chk("rdwr_rehit", 32'(h), 1);
    chk("rdwr_redata", d, 32'hA5A53000);
    chk("rdwr_no_wr", wr_cnt - w0, 0);

    bus.i_rd_en = 1'b1;
    bus.i_addr  = 32'h500;
    @(negedge clk);
    bus.i_rd_en = 1'b0;
    n = 0;
    while (!(bus.i_mem_busy && !bus.o_mem_rd) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_mwait", 32'(n < 50), 1);
    rst_x = 1'b0;
    #1;
    chk("arst_busy", 32'(bus.o_busy), 0);
    chk("arst_data", bus.o_data, 0);
    chk("arst_mem_rd", 32'(bus.o_mem_rd), 0);
    chk("arst_mem_data", bus.o_mem_data, 0);
    chk("arst_mem_mask", 32'(bus.o_mem_mask), 0);
    @(negedge clk);
    rst_x = 1'b1;
    n = 0;
    while (resp_active && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    cpu_read(32'h500, 1'b0, h, d);
    chk("arst_reread_hit", 32'(h), 0);
    chk("arst_reread_data", d, 32'hA5A50500);

    rst_x = 1'b0;
    @(negedge clk);
    rst_x = 1'b1;
    m_clear();
    @(negedge clk);

    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      a = (32'($urandom_range(0, 3)) << 10) |
          (32'($urandom_range(0, 3)) << 2);
      if (r < 2) begin
        cpu_flush(n);
        m_clear();
        chk("rnd_flush_cycles", n, SETS);
      end else if (r < 65) begin
        r0 = rd_cnt;
        h = m_read(a);
        chk("rnd_rd_cnt_pre", 32'(resp_active), 0);
        cpu_read(a, 1'b0, h, d);
        chk($sformatf("rnd%0d_hit_%h", i, a), 32'(h), 32'(rd_cnt == r0));
        chk($sformatf("rnd%0d_data_%h", i, a), d, mem_val(a));
      end else begin
        w0 = wr_cnt;
        d = $urandom;
        m = 4'($urandom_range(0, 15));
        cpu_write(a, d, m);
        chk($sformatf("rnd%0d_wr_cnt", i), wr_cnt - w0, 1);
        chk($sformatf("rnd%0d_wr_mask", i), 32'(last_mask), 32'(m));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_wt_nway.md
# cache_wt_nway

Parametrised N-way set-associative write-through cache sitting between the CPU memory port and the DRAM/peripheral controller. Read hits return data one cycle after acceptance. Read misses fill the selected victim way from memory. Writes update the cached copy on hit (byte-masked, no allocate on miss) and are always forwarded to memory. A flush request invalidates the whole cache.

## Interface
- ADDR_WIDTH, 23: byte-address bits used for tag/index; i_addr[31:ADDR_WIDTH] ignored for tag compare.
- WAYS, 2: associativity; power of 2, 1..8.
- SETS, 256: sets per way; power of 2, ≥2.
- clk  in  1  clock.
- rst_x  in  1  reset, asynchronous, active-low.
- i_rd_en  in  1  read request; sampled only when o_busy=0.
- i_wr_en  in  1  write request; sampled only when o_busy=0.
- i_flush  in  1  invalidate-all request; sampled only when o_busy=0.
- i_addr  in  32  byte address; bits [1:0] ignored.
- i_data  in  32  write data.
- i_mask  in  4  byte enables for writes.
- o_data  out  32  read data.
- o_busy  out  1  1 = request in progress, inputs not sampled.
- o_hit  out  1  1 in LOOKUP cycle when the read hit.
- o_mem_rd / o_mem_wr  out  1  memory read/write request.
- o_mem_addr  out  32  latched request address.
- o_mem_data  out  32  write data to memory.
- o_mem_mask  out  4  write byte enables to memory.
- i_mem_data  in  32  memory read data, valid in the cycle i_mem_busy falls.
- i_mem_busy  in  1  memory busy.

## Operation
- Address split: index = i_addr[2 +: log2(SETS)]; tag = i_addr[ADDR_WIDTH-1 : 2+log2(SETS)].
- Per way and set: valid flop, tag, 32-bit data word. Per set: round-robin victim pointer, log2(WAYS) bits.
- Tag/valid/data arrays are read asynchronously; data may be distributed RAM.
- Request priority when o_busy=0: i_flush > i_rd_en > i_wr_en.
- States:
  - IDLE: accept a request.
    - Read: latch address; go to LOOKUP.
    - Write: compare tag combinationally. On hit, merge i_data into the hit way under i_mask in the same clock edge. Latch addr/data/mask; go to MREQ_WR.
    - Flush: go to FLUSH with set counter = 0.
  - LOOKUP:
    - Hit (any valid way with matching tag): o_hit=1, o_data = hit way word, o_busy=0. A new request is accepted in this cycle with the same priority rules as IDLE. With no new request, go to IDLE.
    - Miss: o_busy=1; go to MREQ_RD.
  - MREQ_RD / MREQ_WR: hold o_mem_rd (or o_mem_wr) high until i_mem_busy=1 is sampled, then drop it and go to MWAIT_RD / MWAIT_WR.
  - MWAIT_RD: on i_mem_busy=0:
    - write i_mem_data into victim way[pointer] and set valid and tag;
    - advance the pointer mod WAYS;
    - capture r_rdata; go to IDLE.
  - MWAIT_WR: on i_mem_busy=0, go to IDLE.
  - FLUSH: clear valid bits of all ways in the current set, one set per cycle. After set SETS-1, reset all pointers to 0 and go to IDLE.
- o_data = hit-way word in a LOOKUP-hit cycle; otherwise r_rdata, held until the next fill.
- Victim choice: an invalid way (lowest index) is preferred over the pointer.
  - When an invalid way is used, the pointer does not advance.
- Write miss: no allocation. Cache contents unchanged.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; pointers 0.
  - o_busy=0, o_hit=0, o_data=0 (r_rdata=0).
  - o_mem_rd=0, o_mem_wr=0, o_mem_addr=0, o_mem_data=0, o_mem_mask=0.
- Reset asserted mid-operation aborts immediately. Any memory request is dropped; no partial fill occurs.
- Read hit latency: data in the cycle after acceptance. Back-to-back hits sustain 1 read per 2 cycles (IDLE→LOOKUP) or 1 per cycle when chained from LOOKUP.
- Read miss: o_busy rises in the LOOKUP cycle. o_busy falls the cycle after i_mem_busy falls; o_data is valid from that cycle.
- Write: o_busy=1 from the cycle after acceptance until the cycle after i_mem_busy falls. The hit update is visible to a read issued immediately afterwards.
- Flush: o_busy=1 for exactly SETS cycles.
- The memory request stays asserted indefinitely if i_mem_busy never rises.

## Test plan
- Reset, read 0x100 (mem returns 0xDEADBEEF) → miss, one o_mem_rd handshake, o_data=0xDEADBEEF. Re-read → o_hit=1 in LOOKUP, no memory traffic.
- WAYS=2, SETS=256: read 0x000, 0x400, 0x800 (same set) → the third read evicts way 0. Read 0x400 hits; read 0x000 misses.
- Write 0x100 data 0x11223344 mask 4'b0101 after cached 0xDEADBEEF → memory sees the write with mask 0101. Re-read hits with 0xDE22BE44.
- Write miss to 0x2000 → memory write only. Read 0x2000 misses.
- Fill four addresses, pulse i_flush → o_busy high for 256 cycles. All four re-reads miss.
- i_rd_en and i_wr_en asserted together → read serviced, write ignored. Assert rst_x=0 during MWAIT_RD → outputs at reset values, and a later read of the same address misses.
